// File: rtl/ren_prf_freelist.sv
// Rename-stage free list of physical register codes. Up to four codes are
// allocated per cycle from the speculative head; retired codes return at the tail.
module ren_prf_freelist #(
  parameter int PRF_NUMS       = 128,
  parameter int PRF_CODE_WIDTH = 7,
  parameter int PTR_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_ren_alloc_req_0,
  input  logic                      i_ren_alloc_req_1,
  input  logic                      i_ren_alloc_req_2,
  input  logic                      i_ren_alloc_req_3,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_alloc_code_0,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_alloc_code_1,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_alloc_code_2,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_alloc_code_3,
  output logic                      o_ren_freelist_stall,
  output logic                      o_ren_prf_free_req_0,
  output logic                      o_ren_prf_free_req_1,
  output logic                      o_ren_prf_free_req_2,
  output logic                      o_ren_prf_free_req_3,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_prf_free_prf_code_0,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_prf_free_prf_code_1,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_prf_free_prf_code_2,
  output logic [PRF_CODE_WIDTH-1:0] o_ren_prf_free_prf_code_3,
  input  logic                      i_rob_commit_vld_0,
  input  logic                      i_rob_commit_vld_1,
  input  logic                      i_rob_commit_vld_2,
  input  logic                      i_rob_commit_vld_3,
  input  logic [PRF_CODE_WIDTH-1:0] i_rob_commit_old_code_0,
  input  logic [PRF_CODE_WIDTH-1:0] i_rob_commit_old_code_1,
  input  logic [PRF_CODE_WIDTH-1:0] i_rob_commit_old_code_2,
  input  logic [PRF_CODE_WIDTH-1:0] i_rob_commit_old_code_3,
  input  logic                      i_flush,
  output logic [PTR_WIDTH-1:0]      o_freelist_cnt
);

  localparam int LANES = 4;

  typedef logic [PRF_CODE_WIDTH-1:0] code_t;
  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [PRF_NUMS-1:0][PRF_CODE_WIDTH-1:0] list_t;

  // Entry i holds code i+1; the last slot wraps to 0, which sits beyond the tail.
  function automatic list_t init_list();
    for (int i = 0; i < PRF_NUMS; i++) begin
      init_list[i] = code_t'(i + 1);
    end
  endfunction

  localparam list_t INIT_LIST = init_list();

  list_t entry_q;
  ptr_t  sh_q;
  ptr_t  ch_q;
  ptr_t  t_q;

  logic [LANES-1:0] alloc_req;
  logic [LANES-1:0] commit_vld;
  logic [LANES-1:0] grant;
  code_t            commit_code [LANES];
  code_t            alloc_code  [LANES];
  code_t            rd_idx      [LANES];
  code_t            wr_idx      [LANES];
  logic [2:0]       n_alloc;
  logic [2:0]       n_commit;
  ptr_t             count;
  logic             stall;

  assign alloc_req  = {i_ren_alloc_req_3, i_ren_alloc_req_2, i_ren_alloc_req_1, i_ren_alloc_req_0};
  assign commit_vld = {i_rob_commit_vld_3, i_rob_commit_vld_2, i_rob_commit_vld_1, i_rob_commit_vld_0};

  assign commit_code[0] = i_rob_commit_old_code_0;
  assign commit_code[1] = i_rob_commit_old_code_1;
  assign commit_code[2] = i_rob_commit_old_code_2;
  assign commit_code[3] = i_rob_commit_old_code_3;

  // Each lane's slot is offset by the number of active lanes below it, so
  // requests are compacted onto consecutive list entries.
  always_comb begin
    n_alloc  = '0;
    n_commit = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_idx[k] = code_t'(sh_q + ptr_t'(n_alloc));
      wr_idx[k] = code_t'(t_q + ptr_t'(n_commit));
      n_alloc   = n_alloc + 3'(alloc_req[k]);
      n_commit  = n_commit + 3'(commit_vld[k]);
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      alloc_code[k] = entry_q[rd_idx[k]];
    end
  end

  assign count = t_q - sh_q;
  assign stall = (ptr_t'(n_alloc) > count) | i_flush;
  assign grant = alloc_req & {LANES{~stall}};

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= INIT_LIST;
      sh_q    <= '0;
      ch_q    <= '0;
      t_q     <= ptr_t'(PRF_NUMS - 1);
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (commit_vld[k]) begin
          entry_q[wr_idx[k]] <= commit_code[k];
        end
      end
      t_q  <= t_q + ptr_t'(n_commit);
      ch_q <= ch_q + ptr_t'(n_commit);
      // Flush rewinds to the committed head after this cycle's retirements.
      if (i_flush) begin
        sh_q <= ch_q + ptr_t'(n_commit);
      end else if (!stall) begin
        sh_q <= sh_q + ptr_t'(n_alloc);
      end
    end
  end

  assign o_ren_freelist_stall = stall;
  assign o_freelist_cnt       = count;

  assign o_ren_alloc_code_0 = alloc_code[0];
  assign o_ren_alloc_code_1 = alloc_code[1];
  assign o_ren_alloc_code_2 = alloc_code[2];
  assign o_ren_alloc_code_3 = alloc_code[3];

  assign o_ren_prf_free_req_0 = grant[0];
  assign o_ren_prf_free_req_1 = grant[1];
  assign o_ren_prf_free_req_2 = grant[2];
  assign o_ren_prf_free_req_3 = grant[3];

  assign o_ren_prf_free_prf_code_0 = alloc_code[0];
  assign o_ren_prf_free_prf_code_1 = alloc_code[1];
  assign o_ren_prf_free_prf_code_2 = alloc_code[2];
  assign o_ren_prf_free_prf_code_3 = alloc_code[3];

endmodule

// File: tb/tb_ren_prf_freelist.sv
// Scoreboard bench for ren_prf_freelist: directed cases with hand-derived
// expectations, then a long randomised alloc/commit/flush run against a FIFO model.
module tb_ren_prf_freelist;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [3:0]      cvld;
  logic [3:0][6:0] old_code;
  logic            flush;
  logic [3:0][6:0] acode;
  logic [3:0][6:0] fcode;
  logic [3:0]      freq;
  logic            stall;
  logic [7:0]      cnt;

  always #5 clk = ~clk;

  ren_prf_freelist dut (
    .clk                       (clk),
    .rst                       (rst),
    .i_ren_alloc_req_0         (req[0]),
    .i_ren_alloc_req_1         (req[1]),
    .i_ren_alloc_req_2         (req[2]),
    .i_ren_alloc_req_3         (req[3]),
    .o_ren_alloc_code_0        (acode[0]),
    .o_ren_alloc_code_1        (acode[1]),
    .o_ren_alloc_code_2        (acode[2]),
    .o_ren_alloc_code_3        (acode[3]),
    .o_ren_freelist_stall      (stall),
    .o_ren_prf_free_req_0      (freq[0]),
    .o_ren_prf_free_req_1      (freq[1]),
    .o_ren_prf_free_req_2      (freq[2]),
    .o_ren_prf_free_req_3      (freq[3]),
    .o_ren_prf_free_prf_code_0 (fcode[0]),
    .o_ren_prf_free_prf_code_1 (fcode[1]),
    .o_ren_prf_free_prf_code_2 (fcode[2]),
    .o_ren_prf_free_prf_code_3 (fcode[3]),
    .i_rob_commit_vld_0        (cvld[0]),
    .i_rob_commit_vld_1        (cvld[1]),
    .i_rob_commit_vld_2        (cvld[2]),
    .i_rob_commit_vld_3        (cvld[3]),
    .i_rob_commit_old_code_0   (old_code[0]),
    .i_rob_commit_old_code_1   (old_code[1]),
    .i_rob_commit_old_code_2   (old_code[2]),
    .i_rob_commit_old_code_3   (old_code[3]),
    .i_flush                   (flush),
    .o_freelist_cnt            (cnt)
  );

  typedef struct packed {
    logic            stall;
    logic [3:0]      mask;
    logic [3:0][6:0] code;
    logic [7:0]      cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   free_q[$];
  int   infl_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation record per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("stall", int'(stall), int'(cur.stall));
      chk("free_req", int'(freq), int'(cur.mask));
      chk("cnt", int'(cnt), int'(cur.cnt));
      for (int k = 0; k < 4; k++) begin
        if (cur.mask[k]) begin
          chk($sformatf("alloc_code_%0d", k), int'(acode[k]), int'(cur.code[k]));
          chk($sformatf("free_prf_code_%0d", k), int'(fcode[k]), int'(cur.code[k]));
        end
      end
    end
  end

  function automatic exp_t mk(input logic s, input logic [3:0] m,
                              input logic [3:0][6:0] c, input logic [7:0] n);
    exp_t e;
    e.stall = s;
    e.mask  = m;
    e.code  = c;
    e.cnt   = n;
    return e;
  endfunction

  task automatic drive(input logic [3:0] r, input logic [3:0] cv,
                       input logic [3:0][6:0] oc, input logic fl, input exp_t e);
    req      = r;
    cvld     = cv;
    old_code = oc;
    flush    = fl;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    cvld     = '0;
    old_code = '0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic model_reset();
    free_q.delete();
    infl_q.delete();
    for (int i = 1; i < 128; i++) free_q.push_back(i);
  endtask

  // One randomised cycle: expectations from the FIFO model, then model update.
  task automatic model_cycle(input int cyc);
    logic [3:0]      r;
    logic [3:0]      cv;
    logic [3:0][6:0] oc;
    logic            fl;
    exp_t            e;
    int              ret[$];
    r  = 4'($urandom_range(0, 15));
    cv = 4'($urandom_range(0, 15));
    fl = (cyc % 41) == 40;
    oc = '0;
    for (int k = 0; k < 4; k++) begin
      if ($countones(cv) > infl_q.size()) begin
        for (int j = 0; j < 4; j++) begin
          if (cv[j] && $countones(cv) > infl_q.size()) cv[j] = 1'b0;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (cv[k]) begin
        oc[k] = 7'(infl_q.pop_front());
        ret.push_back(int'(oc[k]));
      end
    end
    e.cnt   = 8'(free_q.size());
    e.stall = ($countones(r) > free_q.size()) || fl;
    e.mask  = e.stall ? 4'b0000 : r;
    e.code  = '0;
    for (int k = 0; k < 4; k++) begin
      if (e.mask[k]) begin
        e.code[k] = 7'(free_q.pop_front());
        infl_q.push_back(int'(e.code[k]));
      end
    end
    foreach (ret[i]) free_q.push_back(ret[i]);
    if (fl) begin
      for (int i = infl_q.size() - 1; i >= 0; i--) free_q.push_front(infl_q[i]);
      infl_q.delete();
    end
    drive(r, cv, oc, fl, e);
  endtask

  initial begin
    // Reset state, then four lanes at once.
    do_reset();
    drive(4'h0, 4'h0, '0, 1'b0, mk(1'b0, 4'h0, '0, 8'd127));
    drive(4'hf, 4'h0, '0, 1'b0, mk(1'b0, 4'hf, {7'd4, 7'd3, 7'd2, 7'd1}, 8'd127));
    drive(4'h0, 4'h0, '0, 1'b0, mk(1'b0, 4'h0, '0, 8'd123));

    // Sparse lanes compact onto consecutive entries.
    do_reset();
    drive(4'b1010, 4'h0, '0, 1'b0, mk(1'b0, 4'b1010, {7'd2, 7'd0, 7'd1, 7'd0}, 8'd127));
    drive(4'h0, 4'h0, '0, 1'b0, mk(1'b0, 4'h0, '0, 8'd125));

    // Drain to three, stall on four, grant three, then commit while empty.
    do_reset();
    for (int c = 0; c < 31; c++) begin
      drive(4'hf, 4'h0, '0, 1'b0,
            mk(1'b0, 4'hf, {7'(4*c+4), 7'(4*c+3), 7'(4*c+2), 7'(4*c+1)}, 8'(127 - 4*c)));
    end
    drive(4'hf, 4'h0, '0, 1'b0, mk(1'b1, 4'h0, '0, 8'd3));
    drive(4'b0111, 4'h0, '0, 1'b0, mk(1'b0, 4'b0111, {7'd0, 7'd127, 7'd126, 7'd125}, 8'd3));
    drive(4'b0001, 4'b0101, {7'd0, 7'd60, 7'd0, 7'd50}, 1'b0, mk(1'b1, 4'h0, '0, 8'd0));
    drive(4'b0001, 4'h0, '0, 1'b0, mk(1'b0, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd50}, 8'd2));
    drive(4'h0, 4'h0, '0, 1'b0, mk(1'b0, 4'h0, '0, 8'd1));

    // Flush with same-cycle commits rewinds the spec head to ch + m.
    do_reset();
    drive(4'hf, 4'h0, '0, 1'b0, mk(1'b0, 4'hf, {7'd4, 7'd3, 7'd2, 7'd1}, 8'd127));
    drive(4'hf, 4'h0, '0, 1'b0, mk(1'b0, 4'hf, {7'd8, 7'd7, 7'd6, 7'd5}, 8'd123));
    drive(4'b0011, 4'h0, '0, 1'b0, mk(1'b0, 4'b0011, {7'd0, 7'd0, 7'd10, 7'd9}, 8'd119));
    drive(4'h0, 4'hf, {7'd4, 7'd3, 7'd2, 7'd1}, 1'b0, mk(1'b0, 4'h0, '0, 8'd117));
    drive(4'hf, 4'b0011, {7'd0, 7'd0, 7'd6, 7'd5}, 1'b1, mk(1'b1, 4'h0, '0, 8'd121));
    drive(4'b0001, 4'h0, '0, 1'b0, mk(1'b0, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd7}, 8'd127));
    drive(4'h0, 4'h0, '0, 1'b0, mk(1'b0, 4'h0, '0, 8'd126));

    // Long run: pointers wrap several times, lane offsets straddle 127 -> 0.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) model_cycle(c);

    req   = '0;
    cvld  = '0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending records expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
